sdram_demo_sw_debounce: RTL and testbench
=========================================

// Module: sdram_demo_sw_debounce
// PURPOSE
//  Upstream conditioning stage for the slide-switch PIO input port. Takes raw,
//  asynchronous, bouncing switch levels from board pins, synchronises them into
//  clk, debounces each bit independently and drives the clean levels onto the PIO
//  in_port. Also emits per-bit rise/fall strobes and a sticky any-change flag.
// PARAMETERS
//  WIDTH            8       number of switch bits
//  DEBOUNCE_CYCLES  500000  consecutive clk cycles a new level must persist (10 ms @ 50 MHz); legal >= 2
//  CNT_W            $clog2(DEBOUNCE_CYCLES)  per-bit counter width (localparam, derived)
// PORTS
//  clk            in   1      system clock; all logic on rising edge
//  reset          in   1      synchronous, active-high reset
//  sw_raw         in   WIDTH  raw switch pins, asynchronous to clk
//  sw_out         out  WIDTH  debounced levels; connects to PIO in_port
//  rise           out  WIDTH  1-cycle strobe: sw_out[i] went 0->1 this cycle
//  fall           out  WIDTH  1-cycle strobe: sw_out[i] went 1->0 this cycle
//  change_sticky  out  1      set on any rise/fall, held until cleared
//  change_clr     in   1      1-cycle clear request for change_sticky
// BEHAVIOUR
//  Reset (reset=1 at a clk edge): sync1, sync2, sw_out, rise, fall, all counters,
//   change_sticky <= 0. Reset mid-count discards the count; no strobe is produced.
//  Synchroniser: sync1 <= sw_raw; sync2 <= sync1 (2 FF per bit, no logic between).
//  Per-bit FSM, state implied by compare of sync2[i] vs sw_out[i]:
//   STABLE  (sync2[i]==sw_out[i]): cnt[i] <= 0; stays STABLE.
//   PENDING (sync2[i]!=sw_out[i]): if cnt[i]==DEBOUNCE_CYCLES-1 -> sw_out[i] <= sync2[i],
//     cnt[i] <= 0, rise[i] or fall[i] asserted next cycle for exactly 1 cycle;
//     else cnt[i] <= cnt[i]+1.
//   PENDING -> STABLE with cnt cleared whenever sync2[i] returns to sw_out[i]
//   (bounce shorter than DEBOUNCE_CYCLES produces no output change).
//  Latency: a level sampled first at edge k and held appears on sw_out at edge
//   k+DEBOUNCE_CYCLES+1 (DEBOUNCE_CYCLES+2 edges inclusive); rise/fall registered
//   together with sw_out (same edge), deasserted the following edge.
//  Counter never exceeds DEBOUNCE_CYCLES-1; no wrap-around possible.
//  Bits are fully independent; simultaneous transitions on several bits each
//   strobe on their own lane in the same cycle.
//  rise & fall never both high on one bit; rise|fall zero while sw_out is constant.
//  change_sticky: next = (change_sticky & ~change_clr) | (|(rise|fall)) evaluated
//   on the registered strobes; set wins over change_clr in the same cycle.
//  sw_out after reset is 0 regardless of pins; a switch held high at reset
//   produces rise after DEBOUNCE_CYCLES+2 edges (expected, software sees the event).
//  No combinational path from any input to any output.
// TESTING  (DEBOUNCE_CYCLES=4, WIDTH=8)
//  1 Reset: sw_raw=8'hFF during reset -> all outputs 0; release -> sw_out=8'hFF and
//    rise=8'hFF for one cycle exactly 6 edges after release; change_sticky=1 after.
//  2 Clean step: sw_raw[3] 0->1 held -> sw_out[3] rises 6 edges after first sample,
//    rise=8'h08 one cycle, fall=0, other bits unchanged.
//  3 Bounce: sw_raw[0] toggles 1,0,1,0 every 2 cycles then holds 1 -> no strobe during
//    bounce; single rise[0] 6 edges after final stable 1 sampled.
//  4 Glitch reject: sw_raw[5] high for 3 cycles then low -> sw_out, rise, fall unchanged.
//  5 Simultaneous: bits 1 and 7 fall same cycle -> fall=8'h82 in one cycle; change_clr
//    asserted that same cycle -> change_sticky stays 1; clr next cycle alone -> 0.
//  6 Reset mid-count: reset asserted 2 cycles into PENDING -> no strobe; count restarts
//    from 0 after release (full 6-edge latency again).

Source files
------------

// File: rtl/sdram_demo_sw_debounce.sv
// Slide-switch conditioner: 2-FF synchroniser, per-bit debounce, edge strobes, sticky change flag.
// Latency: a level first sampled at edge k appears on sw_out (with its rise/fall strobe) at edge k+DEBOUNCE_CYCLES+1.
// Backpressure: none; free-running, the outputs are plain registered levels and strobes.
//
// Ports:
//   clk            system clock, all logic on the rising edge
//   reset          synchronous active-high reset
//   sw_raw         raw switch pins, asynchronous to clk
//   sw_out         debounced switch levels (to PIO in_port)
//   rise / fall    one-cycle per-bit strobes, registered together with sw_out
//   change_sticky  set by any strobe, held until change_clr (set wins)
//   change_clr     one-cycle clear request for change_sticky
module sdram_demo_sw_debounce #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             change_sticky,
  input  logic             change_clr
);

  localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // The debounce state of a bit is not stored: it is PENDING exactly when the
  // synchronised pin disagrees with the published level.
  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } deb_state_t;

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_sw_out;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic             r_change_sticky;

  logic [WIDTH-1:0] w_sw_out_nxt;
  logic [WIDTH-1:0] w_rise_nxt;
  logic [WIDTH-1:0] w_fall_nxt;
  logic             w_change_sticky_nxt;

  // Plain two-flop synchroniser, nothing between the stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= sw_raw;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    deb_state_t       w_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_out_b;
    logic             w_rise_b;
    logic             w_fall_b;

    always_ff @(posedge clk) begin
      if (reset) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= w_cnt_nxt;
      end
    end

    always_comb begin
      w_state   = (r_sync2[gi] != r_sw_out[gi]) ? ST_PENDING : ST_STABLE;
      w_cnt_nxt = '0;
      w_out_b   = r_sw_out[gi];
      w_rise_b  = 1'b0;
      w_fall_b  = 1'b0;
      case (w_state)
        ST_STABLE: begin
          // Counter held at zero; any bounce that returned here is forgotten.
          w_cnt_nxt = '0;
        end
        ST_PENDING: begin
          if (r_cnt == CNT_MAX) begin
            // New level has persisted long enough: publish it and strobe.
            w_out_b  = r_sync2[gi];
            w_rise_b = r_sync2[gi];
            w_fall_b = ~r_sync2[gi];
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      endcase
    end

    assign w_sw_out_nxt[gi] = w_out_b;
    assign w_rise_nxt[gi]   = w_rise_b;
    assign w_fall_nxt[gi]   = w_fall_b;
  end

  // Sticky flag looks at the already-registered strobes, so it sets one edge
  // after the strobe; a set in the same cycle as a clear takes priority.
  assign w_change_sticky_nxt = (r_change_sticky & ~change_clr) | (|(r_rise | r_fall));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sw_out        <= '0;
      r_rise          <= '0;
      r_fall          <= '0;
      r_change_sticky <= 1'b0;
    end else begin
      r_sw_out        <= w_sw_out_nxt;
      r_rise          <= w_rise_nxt;
      r_fall          <= w_fall_nxt;
      r_change_sticky <= w_change_sticky_nxt;
    end
  end

  assign sw_out        = r_sw_out;
  assign rise          = r_rise;
  assign fall          = r_fall;
  assign change_sticky = r_change_sticky;

endmodule

// File: tb/tb_sdram_demo_sw_debounce.sv
module tb_sdram_demo_sw_debounce;
  localparam int WIDTH = 8;
  localparam int DC    = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             change_clr;
  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] sw_out;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             change_sticky;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sdram_demo_sw_debounce #(
    .WIDTH          (WIDTH),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sw_raw       (sw_raw),
    .sw_out       (sw_out),
    .rise         (rise),
    .fall         (fall),
    .change_sticky(change_sticky),
    .change_clr   (change_clr)
  );

  // Reference model. m_samp holds the pin samples of the last two edges
  // (oldest first): the value a bit "sees" at an edge is the one sampled two
  // edges earlier. Each bit remembers the last edge at which it was settled
  // (pin agreed with output, output flipped, or reset); the output flips once
  // the pin has disagreed for DC consecutive edges after that.
  logic [WIDTH-1:0] m_out, m_rise, m_fall;
  logic             m_sticky;
  logic [WIDTH-1:0] m_samp[$];
  int               m_settle[WIDTH];
  int               m_edge = 0;

  initial begin
    forever begin : mdl
      logic [WIDTH-1:0] seen, nr, nf;
      logic             ns;
      @(posedge clk);
      m_edge++;
      if (reset) begin
        m_out    = '0;
        m_rise   = '0;
        m_fall   = '0;
        m_sticky = 1'b0;
        m_samp   = {8'h00, 8'h00};
        for (int i = 0; i < WIDTH; i++) m_settle[i] = m_edge;
      end else begin
        seen = m_samp[0];
        ns   = (m_sticky & ~change_clr) | (|(m_rise | m_fall));
        nr   = '0;
        nf   = '0;
        for (int i = 0; i < WIDTH; i++) begin
          if (seen[i] == m_out[i]) begin
            m_settle[i] = m_edge;
          end else if (m_edge - m_settle[i] == DC) begin
            nr[i]       = seen[i];
            nf[i]       = ~seen[i];
            m_out[i]    = seen[i];
            m_settle[i] = m_edge;
          end
        end
        m_rise   = nr;
        m_fall   = nf;
        m_sticky = ns;
        m_samp.push_back(sw_raw);
        void'(m_samp.pop_front());
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1; sw_raw = 8'hFF; change_clr = 1'b0;
    repeat (3) begin
      @(negedge clk);
      total++;
      if ({sw_out, rise, fall, change_sticky} !== 25'd0) begin
        bad++;
        $display("FAIL reset_hold: got out=%h rise=%h fall=%h sticky=%b want all 0", sw_out, rise, fall, change_sticky);
      end
    end
    reset = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      total++;
      if ({sw_out, rise, fall, change_sticky} !== {m_out, m_rise, m_fall, m_sticky}) begin
        bad++;
        $display("FAIL reset_model c=%0d: got %h/%h/%h/%b want %h/%h/%h/%b", c, sw_out, rise, fall, change_sticky, m_out, m_rise, m_fall, m_sticky);
      end
      if (c == 5) begin
        total++;
        if (sw_out !== 8'h00) begin bad++; $display("FAIL reset_early: got out=%h want 00", sw_out); end
      end
      if (c == 6) begin
        total++;
        if (sw_out !== 8'hFF || rise !== 8'hFF) begin bad++; $display("FAIL reset_release: got out=%h rise=%h want FF/FF", sw_out, rise); end
      end
      if (c == 7) begin
        total++;
        if (rise !== 8'h00 || change_sticky !== 1'b1) begin bad++; $display("FAIL reset_after: got rise=%h sticky=%b want 00/1", rise, change_sticky); end
      end
    end
  endtask

  task automatic test_clean_step();
    sw_raw = 8'h00;
    repeat (10) begin
      @(negedge clk);
      total++;
      if ({sw_out, rise, fall, change_sticky} !== {m_out, m_rise, m_fall, m_sticky}) begin
        bad++;
        $display("FAIL clear_model: got %h/%h/%h/%b want %h/%h/%h/%b", sw_out, rise, fall, change_sticky, m_out, m_rise, m_fall, m_sticky);
      end
    end
    sw_raw = 8'h08;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      total++;
      if ({sw_out, rise, fall, change_sticky} !== {m_out, m_rise, m_fall, m_sticky}) begin
        bad++;
        $display("FAIL step_model c=%0d: got %h/%h/%h/%b want %h/%h/%h/%b", c, sw_out, rise, fall, change_sticky, m_out, m_rise, m_fall, m_sticky);
      end
      if (c == 5) begin
        total++;
        if (sw_out !== 8'h00 || rise !== 8'h00) begin bad++; $display("FAIL step_early: got out=%h rise=%h want 00/00", sw_out, rise); end
      end
      if (c == 6) begin
        total++;
        if (sw_out !== 8'h08 || rise !== 8'h08 || fall !== 8'h00) begin
          bad++; $display("FAIL step_edge: got out=%h rise=%h fall=%h want 08/08/00", sw_out, rise, fall);
        end
      end
      if (c == 7) begin
        total++;
        if (rise !== 8'h00) begin bad++; $display("FAIL step_pulse: got rise=%h want 00", rise); end
      end
    end
  endtask

  task automatic test_bounce();
    logic [7:0] pat[8];
    pat = '{8'h09, 8'h09, 8'h08, 8'h08, 8'h09, 8'h09, 8'h08, 8'h08};
    for (int j = 0; j < 8; j++) begin
      sw_raw = pat[j];
      @(negedge clk);
      total++;
      if ((rise | fall) !== 8'h00 || sw_out !== 8'h08) begin
        bad++; $display("FAIL bounce_quiet j=%0d: got out=%h rise=%h fall=%h want 08/00/00", j, sw_out, rise, fall);
      end
    end
    sw_raw = 8'h09;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      total++;
      if ({sw_out, rise, fall, change_sticky} !== {m_out, m_rise, m_fall, m_sticky}) begin
        bad++;
        $display("FAIL bounce_model c=%0d: got %h/%h/%h/%b want %h/%h/%h/%b", c, sw_out, rise, fall, change_sticky, m_out, m_rise, m_fall, m_sticky);
      end
      total++;
      if (rise !== ((c == 6) ? 8'h01 : 8'h00) || fall !== 8'h00) begin
        bad++; $display("FAIL bounce_edge c=%0d: got rise=%h fall=%h", c, rise, fall);
      end
    end
  endtask

  task automatic test_glitch();
    for (int c = 0; c < 13; c++) begin
      sw_raw = (c < 3) ? 8'h29 : 8'h09;
      @(negedge clk);
      total++;
      if (sw_out !== 8'h09 || rise !== 8'h00 || fall !== 8'h00) begin
        bad++; $display("FAIL glitch c=%0d: got out=%h rise=%h fall=%h want 09/00/00", c, sw_out, rise, fall);
      end
    end
  endtask

  task automatic test_simultaneous();
    sw_raw = 8'h8B;
    repeat (10) @(negedge clk);
    total++;
    if (sw_out !== 8'h8B) begin bad++; $display("FAIL simul_setup: got out=%h want 8B", sw_out); end
    change_clr = 1'b1;
    @(negedge clk);
    change_clr = 1'b0;
    total++;
    if (change_sticky !== 1'b0) begin bad++; $display("FAIL sticky_clear: got %b want 0", change_sticky); end
    sw_raw = 8'h09;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      total++;
      if ({sw_out, rise, fall, change_sticky} !== {m_out, m_rise, m_fall, m_sticky}) begin
        bad++;
        $display("FAIL simul_model c=%0d: got %h/%h/%h/%b want %h/%h/%h/%b", c, sw_out, rise, fall, change_sticky, m_out, m_rise, m_fall, m_sticky);
      end
      if (c == 6) begin
        total++;
        if (fall !== 8'h82 || rise !== 8'h00) begin bad++; $display("FAIL simul_fall: got fall=%h rise=%h want 82/00", fall, rise); end
        change_clr = 1'b1;
      end
      if (c == 7) begin
        total++;
        if (change_sticky !== 1'b1) begin bad++; $display("FAIL set_wins: got sticky=%b want 1", change_sticky); end
      end
      if (c == 8) begin
        total++;
        if (change_sticky !== 1'b0) begin bad++; $display("FAIL clr_alone: got sticky=%b want 0", change_sticky); end
        change_clr = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid();
    sw_raw = 8'h29;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      total++;
      if (rise !== 8'h00 || sw_out !== 8'h09) begin bad++; $display("FAIL mid_pre c=%0d: got out=%h rise=%h want 09/00", c, sw_out, rise); end
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if ({sw_out, rise, fall, change_sticky} !== 25'd0) begin
      bad++; $display("FAIL mid_reset: got out=%h rise=%h fall=%h sticky=%b want all 0", sw_out, rise, fall, change_sticky);
    end
    for (int d = 1; d <= 8; d++) begin
      @(negedge clk);
      total++;
      if (sw_out !== ((d >= 6) ? 8'h29 : 8'h00) || rise !== ((d == 6) ? 8'h29 : 8'h00) || fall !== 8'h00) begin
        bad++; $display("FAIL mid_restart d=%0d: got out=%h rise=%h fall=%h", d, sw_out, rise, fall);
      end
    end
  endtask

  task automatic test_random();
    logic bouncy;
    bouncy = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (c % 20 == 0) bouncy = $urandom_range(0, 1) == 1;
      if (bouncy) sw_raw = sw_raw ^ 8'($urandom & $urandom);
      else if ($urandom_range(0, 15) == 0) sw_raw = sw_raw ^ 8'($urandom);
      change_clr = ($urandom_range(0, 7) == 0);
      reset      = ($urandom_range(0, 149) == 0);
      @(negedge clk);
      total++;
      if ({sw_out, rise, fall, change_sticky} !== {m_out, m_rise, m_fall, m_sticky}) begin
        bad++;
        $display("FAIL random_model c=%0d: got %h/%h/%h/%b want %h/%h/%h/%b", c, sw_out, rise, fall, change_sticky, m_out, m_rise, m_fall, m_sticky);
      end
      if ((rise & fall) !== 8'h00) begin
        bad++; $display("FAIL random_excl c=%0d: got rise=%h fall=%h want disjoint", c, rise, fall);
      end
    end
    reset = 1'b0;
    change_clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clean_step();
    test_bounce();
    test_glitch();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
